// File: rtl/freq_divider_prog.sv
// Programmable integer clock divider: divides clk by R in 1..2^WIDTH-1 with near-50% duty.
// Ratio updates arrive through a valid/ready handshake and take effect only on a period wrap.
module freq_divider_prog #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned RESET_DIV = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] ndiv,
  input  logic             ndiv_valid,
  output logic             ndiv_ready,
  output logic             freq_div_out,
  output logic             tc_pulse,
  output logic [WIDTH-1:0] phase_cnt
);

  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] RST_R   = RESET_DIV[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_CNT = (RESET_DIV == 0) ? ZERO : RST_R - ONE;

  logic [WIDTH-1:0] r_ratio;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_shadow;
  logic             r_pending;
  logic             r_out;
  logic             r_tc;

  logic [WIDTH:0]   w_high;
  logic [WIDTH-1:0] w_cnt_next;
  logic             w_halt;
  logic             w_last;
  logic             w_wrap;
  logic             w_xfer;
  logic             w_apply;

  // Period bookkeeping: high time is one bit wider so R = 2^WIDTH-1 cannot overflow.
  always_comb begin
    w_high  = ({1'b0, r_ratio} + {ZERO, 1'b1}) >> 1;
    w_halt  = (r_ratio == ZERO);
    w_last  = (r_cnt == (r_ratio - ONE));
    w_wrap  = w_halt | (en & w_last);
    w_xfer  = ndiv_valid & ~r_pending;
    w_apply = w_wrap & r_pending;
    if (w_last) begin
      w_cnt_next = ZERO;
    end else begin
      w_cnt_next = r_cnt + ONE;
    end
  end

  // Handshake capture of the shadow ratio and pending flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow  <= ZERO;
      r_pending <= 1'b0;
    end else if (w_xfer) begin
      r_shadow  <= ndiv;
      r_pending <= 1'b1;
    end else if (w_apply) begin
      r_pending <= 1'b0;
    end else begin
      r_pending <= r_pending;
    end
  end

  // Phase counter, active ratio and registered outputs; a halted divider still wraps every edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ratio <= RST_R;
      r_cnt   <= RST_CNT;
      r_out   <= 1'b0;
      r_tc    <= 1'b0;
    end else if (w_apply) begin
      r_ratio <= r_shadow;
      r_cnt   <= ZERO;
      r_out   <= (r_shadow != ZERO);
      r_tc    <= (r_shadow != ZERO);
    end else if (w_halt) begin
      r_cnt <= ZERO;
      r_out <= 1'b0;
      r_tc  <= 1'b0;
    end else if (en) begin
      r_cnt <= w_cnt_next;
      r_out <= ({1'b0, w_cnt_next} < w_high);
      r_tc  <= (w_cnt_next == ZERO);
    end else begin
      r_tc <= 1'b0;
    end
  end

  assign ndiv_ready   = ~r_pending;
  assign freq_div_out = r_out;
  assign tc_pulse     = r_tc;
  assign phase_cnt    = r_cnt;

endmodule
